// File: rtl/kyber_rej_sampler_pkg.sv
// Shared parameters, types and FSM encodings for the Kyber Parse rejection sampler.
// Ports: none (package).
// Contents: word/coefficient widths, modulus, polynomial length, staging geometry, state constants.
package kyber_rej_sampler_pkg;

  localparam int BW_DATA   = 64;    // squeezed word width, 8 bytes
  localparam int KYBER_Q   = 3329;  // modulus; candidates below it are accepted
  localparam int KYBER_N   = 256;   // coefficients per polynomial
  localparam int BW_COEF   = 12;    // coefficient width

  // Staging holds a partial triplet (up to 2 bytes) plus one full word.
  localparam int STAGE_BYTES = 10;
  localparam int BW_STAGE    = 8 * STAGE_BYTES;

  typedef logic [BW_COEF-1:0] coef_t;

  localparam coef_t KYBER_Q_C = coef_t'(KYBER_Q);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/kyber_rej_sampler_if.sv
// Byte-stream input and coefficient output bus of the rejection sampler.
// Ports: ibytes/ibytes_valid/ibytes_done from the sponge (no ready: words must be taken),
//        coef0/coef1/coef_valid/coef_idx towards the polynomial RAM writer.
interface kyber_rej_sampler_if;
  import kyber_rej_sampler_pkg::*;

  logic [BW_DATA-1:0] ibytes;
  logic               ibytes_valid;
  logic               ibytes_done;
  coef_t              coef0;
  coef_t              coef1;
  logic [1:0]         coef_valid;
  logic [7:0]         coef_idx;

  // Sampler side.
  modport slave (
    input  ibytes, ibytes_valid, ibytes_done,
    output coef0, coef1, coef_valid, coef_idx
  );

  // Environment side: sponge driver plus coefficient consumer.
  modport master (
    output ibytes, ibytes_valid, ibytes_done,
    input  coef0, coef1, coef_valid, coef_idx
  );

endinterface

// File: rtl/kyber_rej_sampler_sync_fifo.sv
// Word FIFO absorbing the sponge burst; synchronous active-high reset plus a flush input.
// Latency: written word is readable the cycle after the write; read data is combinational from the head.
// Backpressure: none upstream; a write while full is dropped and reported through o_full.
// Ports: i_clk, i_rst, i_clr (flush), i_wr_en/i_wr_data, i_rd_en/o_rd_data, o_full, o_empty.
module kyber_rej_sampler_sync_fifo #(
  parameter int BW    = 64,
  parameter int DEPTH = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [BW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [BW-1:0] o_rd_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_wr;
  logic w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kyber_rej_sampler.sv
// Kyber Parse rejection sampler: squeezed bytes in, up to two uniform coefficients mod q out per cycle.
// Latency: first coefficient is registered 3 cycles after the first word arrives in RUN; 3 bytes/cycle sustained.
// Backpressure: none accepted from the sponge; words are buffered in a FIFO and dropped (o_overflow) when full.
// Ports: i_clk, i_rst (sync, active-high), i_start, io_bus (stream in / coefficients out),
//        o_busy, o_done, o_error (input ran dry), o_overflow (FIFO dropped a word).
module kyber_rej_sampler
  import kyber_rej_sampler_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  kyber_rej_sampler_if.slave   io_bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_overflow
);

  logic [1:0]          r_state;
  logic                r_done_seen;
  logic [8:0]          r_cnt;
  logic [BW_STAGE-1:0] r_stage;      // oldest byte in the top byte lane
  logic [3:0]          r_stage_cnt;
  coef_t               r_coef0;
  coef_t               r_coef1;
  logic [1:0]          r_vld;
  logic [7:0]          r_idx;
  logic                r_done;
  logic                r_error;
  logic                r_overflow;

  logic                w_run;
  logic                w_wr;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [BW_DATA-1:0]  w_fifo_rdata;
  logic                w_take;
  logic [3:0]          w_rem;
  logic                w_pop;
  logic [BW_STAGE-1:0] w_shifted;
  logic [BW_STAGE-1:0] w_pop_word;
  logic [BW_STAGE-1:0] w_stage_nxt;
  logic [3:0]          w_stage_cnt_nxt;
  logic [7:0]          w_b0;
  logic [7:0]          w_b1;
  logic [7:0]          w_b2;
  coef_t               w_d1;
  coef_t               w_d2;
  logic                w_acc1;
  logic                w_acc2;
  logic                w_last;
  coef_t               w_lane0;
  logic [1:0]          w_vld;
  logic [1:0]          w_n_emit;
  logic [8:0]          w_cnt_nxt;
  logic                w_final;
  logic                w_starved;

  assign w_run = (r_state == ST_RUN);
  assign w_wr  = w_run & io_bus.ibytes_valid;

  // Outside RUN the FIFO is held flushed: IDLE ignores input, DRAIN discards it.
  kyber_rej_sampler_sync_fifo #(
    .BW    (BW_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (~w_run),
    .i_wr_en   (w_wr),
    .i_wr_data (io_bus.ibytes),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Staging: consume a triplet when one is available, refill with a whole word
  // whenever fewer than 3 bytes would remain, so the next cycle can always take.
  assign w_take          = w_run & (r_stage_cnt >= 4'd3);
  assign w_rem           = r_stage_cnt - (w_take ? 4'd3 : 4'd0);
  assign w_pop           = w_run & (w_rem < 4'd3) & ~w_fifo_empty;
  assign w_shifted       = w_take ? {r_stage[BW_STAGE-25:0], 24'd0} : r_stage;
  // New word lands directly behind the w_rem surviving bytes. Bytes past the
  // count are always zero, so OR-merging is safe.
  assign w_pop_word      = {w_fifo_rdata, {(BW_STAGE-BW_DATA){1'b0}}} >> {w_rem, 3'b000};
  assign w_stage_nxt     = w_pop ? (w_shifted | w_pop_word) : w_shifted;
  assign w_stage_cnt_nxt = w_rem + (w_pop ? 4'd8 : 4'd0);

  // Parse: two 12-bit little-endian candidates from three bytes.
  assign w_b0   = r_stage[BW_STAGE-1  -: 8];
  assign w_b1   = r_stage[BW_STAGE-9  -: 8];
  assign w_b2   = r_stage[BW_STAGE-17 -: 8];
  assign w_d1   = {w_b1[3:0], w_b0};
  assign w_d2   = {w_b2, w_b1[7:4]};
  assign w_acc1 = w_take & (w_d1 < KYBER_Q_C);
  assign w_acc2 = w_take & (w_d2 < KYBER_Q_C);
  assign w_last = (r_cnt == 9'(KYBER_N-1));

  // Accepted values pack into lane 0 first; with one slot left only lane 0 goes out.
  always_comb begin
    w_lane0 = w_acc1 ? w_d1 : w_d2;
    w_vld   = 2'b00;
    if (w_acc1 && w_acc2 && !w_last) begin
      w_vld = 2'b11;
    end else if (w_acc1 || w_acc2) begin
      w_vld = 2'b01;
    end
  end

  assign w_n_emit  = {1'b0, w_vld[1]} + {1'b0, w_vld[0]};
  assign w_cnt_nxt = r_cnt + {7'd0, w_n_emit};
  assign w_final   = (w_vld != 2'b00) & (w_cnt_nxt == 9'(KYBER_N));
  assign w_starved = r_done_seen & w_fifo_empty & (r_stage_cnt < 4'd3) & (r_cnt < 9'(KYBER_N));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_done_seen <= 1'b0;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_stage_cnt <= '0;
      r_coef0     <= '0;
      r_coef1     <= '0;
      r_vld       <= 2'b00;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_vld  <= 2'b00;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_RUN;
            r_done_seen <= 1'b0;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_stage_cnt <= '0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (io_bus.ibytes_done) begin
            r_done_seen <= 1'b1;
          end
          if (w_wr && w_fifo_full) begin
            r_overflow <= 1'b1;
          end
          r_stage     <= w_stage_nxt;
          r_stage_cnt <= w_stage_cnt_nxt;
          if (w_vld != 2'b00) begin
            r_vld <= w_vld;
            r_cnt <= w_cnt_nxt;
            r_idx <= r_cnt[7:0];
            r_coef0 <= w_lane0;
            if (w_vld[1]) begin
              r_coef1 <= w_d2;
            end
          end
          if (w_final) begin
            r_done  <= 1'b1;
            r_state <= ST_DRAIN;
          end else if (w_starved) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          r_stage     <= '0;
          r_stage_cnt <= '0;
          if (io_bus.ibytes_done) begin
            r_done_seen <= 1'b1;
          end
          if (r_done_seen || io_bus.ibytes_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.coef0      = r_coef0;
  assign io_bus.coef1      = r_coef1;
  assign io_bus.coef_valid = r_vld;
  assign io_bus.coef_idx   = r_idx;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_overflow        = r_overflow;

endmodule
